// File: rtl/dispatcher_done_pkg.sv
// Shared definitions for the dispatcher wavefront-completion path:
// default sizing, the dealloc entry layout and a constant clog2 helper.
package dispatcher_done_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NUMBER_CU   = 8;
  localparam int CU_ID_WIDTH = clog2(NUMBER_CU);
  localparam int TAG_WIDTH   = 15;
  localparam int FIFO_DEPTH  = 4;

  typedef struct packed {
    logic [CU_ID_WIDTH-1:0] cu_id;
    logic [TAG_WIDTH-1:0]   wf_tag;
  } dealloc_entry_t;

endpackage

// File: rtl/wf_done_fifo.sv
// Single-push/single-pop synchronous FIFO holding finished-wavefront tags
// for one CU. A push into a full FIFO is accepted only when a pop happens
// on the same edge; otherwise it is ignored (the caller flags the drop).
module wf_done_fifo #(
  parameter int DATA_W = 15,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic               full,
  output logic               empty,
  output logic [PTR_W:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cu_wf_done_collector.sv
// Collects per-CU wavefront-done pulses into per-CU FIFOs and drains them
// round-robin into one registered valid/ready dealloc stream.
// Optional feature macro: WF_DONE_COUNT_EN adds a 32-bit handshake counter
// on port dealloc_count.
module cu_wf_done_collector #(
  parameter int NUMBER_CU      = dispatcher_done_pkg::NUMBER_CU,
  parameter int CU_ID_WIDTH    = dispatcher_done_pkg::clog2(NUMBER_CU),
  parameter int TAG_WIDTH      = dispatcher_done_pkg::TAG_WIDTH,
  parameter int FIFO_DEPTH     = dispatcher_done_pkg::FIFO_DEPTH,
  parameter int FIFO_PTR_WIDTH = dispatcher_done_pkg::clog2(FIFO_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUMBER_CU-1:0]           cu2dispatch_wf_done,
  input  logic [NUMBER_CU*TAG_WIDTH-1:0] cu2dispatch_wf_tag_done,
  output logic                           dealloc_valid,
  input  logic                           dealloc_ready,
  output logic [CU_ID_WIDTH-1:0]         dealloc_cu_id,
  output logic [TAG_WIDTH-1:0]           dealloc_wf_tag,
  output logic                           collector_empty,
`ifdef WF_DONE_COUNT_EN
  output logic [31:0]                    dealloc_count,
`endif
  output logic                           collector_overflow
);

  logic [TAG_WIDTH-1:0]    fifo_dout  [NUMBER_CU];
  logic [FIFO_PTR_WIDTH:0] fifo_count [NUMBER_CU];
  logic [NUMBER_CU-1:0]    fifo_full;
  logic [NUMBER_CU-1:0]    fifo_empty;
  logic [NUMBER_CU-1:0]    fifo_pop;
  logic [NUMBER_CU-1:0]    fifo_idle;

  logic [CU_ID_WIDTH-1:0]  rr_ptr;
  logic [CU_ID_WIDTH-1:0]  grant_idx;
  logic [CU_ID_WIDTH-1:0]  rr_next;
  logic                    grant_vld;
  logic                    load;

  for (genvar i = 0; i < NUMBER_CU; i++) begin : g_cu
    wf_done_fifo #(
      .DATA_W (TAG_WIDTH),
      .DEPTH  (FIFO_DEPTH),
      .PTR_W  (FIFO_PTR_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cu2dispatch_wf_done[i]),
      .pop   (fifo_pop[i]),
      .din   (cu2dispatch_wf_tag_done[i*TAG_WIDTH +: TAG_WIDTH]),
      .dout  (fifo_dout[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_count[i])
    );
    assign fifo_idle[i] = (fifo_count[i] == '0);
  end

  // The output register may take a new entry when empty or being drained.
  assign load            = !dealloc_valid || dealloc_ready;
  assign collector_empty = !dealloc_valid && (&fifo_idle);
  assign rr_next         = (int'(grant_idx) == NUMBER_CU - 1) ? '0 : grant_idx + CU_ID_WIDTH'(1);

  // Round-robin search: first non-empty FIFO at or above rr_ptr, with wrap.
  always_comb begin : arb
    int k;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int j = 0; j < NUMBER_CU; j++) begin
      k = int'(rr_ptr) + j;
      if (k >= NUMBER_CU) k = k - NUMBER_CU;
      if (!grant_vld && !fifo_empty[k]) begin
        grant_vld = 1'b1;
        grant_idx = CU_ID_WIDTH'(k);
      end
    end
  end

  // Pop only the winning FIFO, and only when its entry is actually loaded.
  always_comb begin
    fifo_pop = '0;
    if (load && grant_vld) fifo_pop[grant_idx] = 1'b1;
  end

  // Output register and arbitration pointer advance together on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      dealloc_valid  <= 1'b0;
      dealloc_cu_id  <= '0;
      dealloc_wf_tag <= '0;
      rr_ptr         <= '0;
    end else if (load) begin
      dealloc_valid <= grant_vld;
      if (grant_vld) begin
        dealloc_cu_id  <= grant_idx;
        dealloc_wf_tag <= fifo_dout[grant_idx];
        rr_ptr         <= rr_next;
      end
    end
  end

  // Sticky drop flag: a pulse hit a full FIFO that was not popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      collector_overflow <= 1'b0;
    end else if (|(cu2dispatch_wf_done & fifo_full & ~fifo_pop)) begin
      collector_overflow <= 1'b1;
    end
  end

`ifdef WF_DONE_COUNT_EN
  // Completed-handshake counter, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      dealloc_count <= '0;
    end else if (dealloc_valid && dealloc_ready) begin
      dealloc_count <= dealloc_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cu_wf_done_collector.sv
// Directed bench for cu_wf_done_collector: single completion, simultaneous
// completions, round-robin fairness, backpressure, overflow and reset.
module tb_cu_wf_done_collector;
  import dispatcher_done_pkg::*;

  localparam int NCU = 8;
  localparam int TW  = 15;

  logic              clk;
  logic              rst;
  logic [NCU-1:0]    done;
  logic [NCU*TW-1:0] tags;
  logic              ready;
  logic              valid;
  logic [2:0]        cu_id;
  logic [TW-1:0]     wf_tag;
  logic              empty;
  logic              overflow;
`ifdef WF_DONE_COUNT_EN
  logic [31:0]       count;
`endif

  int checks = 0;
  int errors = 0;
  dealloc_entry_t exp_e;

  cu_wf_done_collector dut (
    .clk                     (clk),
    .rst                     (rst),
    .cu2dispatch_wf_done     (done),
    .cu2dispatch_wf_tag_done (tags),
    .dealloc_valid           (valid),
    .dealloc_ready           (ready),
    .dealloc_cu_id           (cu_id),
    .dealloc_wf_tag          (wf_tag),
    .collector_empty         (empty),
`ifdef WF_DONE_COUNT_EN
    .dealloc_count           (count),
`endif
    .collector_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0] ecu, input logic [TW-1:0] etag);
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk({name, "_cu"}, 32'(cu_id), 32'(ecu));
    chk({name, "_tag"}, 32'(wf_tag), 32'(etag));
  endtask

  task automatic do_reset();
    done = '0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; done = '0; tags = '0; ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cu", 32'(cu_id), 32'd0);
    chk("rst_tag", 32'(wf_tag), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef WF_DONE_COUNT_EN
    chk("rst_count", count, 32'd0);
`endif
    rst = 1'b0;

    // Single completion on CU3
    ready = 1'b1;
    tags[3*TW +: TW] = 15'h0123;
    done[3] = 1'b1;
    tick();
    done = '0;
    chk("single_lat_valid", 32'(valid), 32'd0);
    chk("single_lat_empty", 32'(empty), 32'd0);
    tick();
    chk_out("single", 3'd3, 15'h0123);
    tick();
    chk("single_after_valid", 32'(valid), 32'd0);
    chk("single_after_empty", 32'(empty), 32'd1);

    // All CUs finish at once; rr_ptr back at 0
    do_reset();
`ifdef WF_DONE_COUNT_EN
    chk("count_after_rst", count, 32'd0);
`endif
    for (int i = 0; i < NCU; i++) tags[i*TW +: TW] = TW'(i);
    done = 8'hFF;
    tick();
    done = '0;
    chk("simul_lat_valid", 32'(valid), 32'd0);
    for (int k = 0; k < NCU; k++) begin
      tick();
      chk_out($sformatf("simul_%0d", k), 3'(k), TW'(k));
    end
    tick();
    chk("simul_end_valid", 32'(valid), 32'd0);
    chk("simul_end_empty", 32'(empty), 32'd1);
`ifdef WF_DONE_COUNT_EN
    chk("simul_count", count, 32'd8);
`endif

    // Fairness: CU2 and CU5 refilled every cycle
    tags[2*TW +: TW] = 15'h0222;
    tags[5*TW +: TW] = 15'h0555;
    done = 8'b0010_0100;
    tick();
    chk("fair_lat_valid", 32'(valid), 32'd0);
    tick(); chk_out("fair_0", 3'd2, 15'h0222);
    tick(); chk_out("fair_1", 3'd5, 15'h0555);
    tick(); chk_out("fair_2", 3'd2, 15'h0222);
    tick(); chk_out("fair_3", 3'd5, 15'h0555);
    done = '0;
    do_reset();

    // Backpressure with three entries queued
    ready = 1'b0;
    tags[1*TW +: TW] = 15'h0011;
    tags[4*TW +: TW] = 15'h0044;
    tags[6*TW +: TW] = 15'h0066;
    done = 8'b0101_0010;
    tick();
    done = '0;
    chk("bp_lat_valid", 32'(valid), 32'd0);
    tick();
    exp_e.cu_id  = 3'd1;
    exp_e.wf_tag = 15'h0011;
    chk_out("bp_first", exp_e.cu_id, exp_e.wf_tag);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("bp_hold_%0d", c), exp_e.cu_id, exp_e.wf_tag);
    end
    ready = 1'b1;
    tick(); chk_out("bp_xfer_4", 3'd4, 15'h0044);
    tick(); chk_out("bp_xfer_6", 3'd6, 15'h0066);
    tick();
    chk("bp_end_valid", 32'(valid), 32'd0);
    chk("bp_end_empty", 32'(empty), 32'd1);
    do_reset();

    // Overflow: CU0 entry stalls the output, then five pulses on CU1
    ready = 1'b0;
    tags[0*TW +: TW] = 15'h00AA;
    done[0] = 1'b1;
    tick();
    done = '0;
    for (int p = 1; p <= 5; p++) begin
      tags[1*TW +: TW] = TW'(p);
      done[1] = 1'b1;
      tick();
      if (p == 1) chk_out("ovf_stall", 3'd0, 15'h00AA);
      if (p == 4) chk("ovf_after4", 32'(overflow), 32'd0);
      if (p == 5) chk("ovf_after5", 32'(overflow), 32'd1);
    end
    done = '0;
    tick();
    chk_out("ovf_held", 3'd0, 15'h00AA);
    ready = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      tick();
      chk_out($sformatf("ovf_drain_%0d", p), 3'd1, TW'(p));
    end
    tick();
    chk("ovf_end_valid", 32'(valid), 32'd0);
    chk("ovf_end_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of queued traffic (overflow still set here)
    ready = 1'b0;
    for (int i = 0; i < NCU; i++) tags[i*TW +: TW] = 15'h007F;
    done = 8'hFF;
    tick(); tick();
    done = '0;
    chk("mid_pre_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_ovf", 32'(overflow), 32'd0);
`ifdef WF_DONE_COUNT_EN
    chk("mid_count", count, 32'd0);
`endif
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_stale_%0d", c), 32'(valid), 32'd0);
    end
    chk("mid_final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
